pulse_seq_ctrl: RTL
===================

Name: pulse_seq_ctrl

Overview:
- Configuration sequencer for the N-channel pulse generator core.
- Accepts a 32-bit command word stream (valid/ready) and stages period, outer_period, state0 and edge entries in a shadow bank.
- Swaps the shadow bank into the active bank driving the core only at an outer-frame boundary, or immediately when stopped.
- Owns the core's reset and tracks the core's frame position with a mirror counter.

Parameters:
- COUNT_BITS, 32, counter/edge value width; legal range 1..32.
- CH_LOG2, 3, log2 of channel count; CH_MAX = 1 << CH_LOG2.
- ED_MAX, 16, number of edge slots.
- ED_BITS (local), 1 + CH_LOG2 + 2*COUNT_BITS, edge packing {dx, x, ch_id, toggle}; toggle is the LSB.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_data  in  32  command/payload word.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  word accepted when cmd_valid && cmd_ready.
- period  out  COUNT_BITS  active inner period to the core.
- outer_period  out  COUNT_BITS  active outer period.
- state0  out  CH_MAX  active initial state.
- eds  out  ED_BITS*ED_MAX  active edge table, slot i at [i*ED_BITS +: ED_BITS].
- pl_reset  out  1  synchronous reset to the core.
- running  out  1  sequencer running.
- commit_pending  out  1  commit requested, not yet applied.
- err  out  1  sticky protocol error.

Behaviour:
- Async reset clears all shadow and active registers and the mirror counter to 0.
- Outputs during and after reset: running=0, pl_reset=1, err=0, commit_pending=0, cmd_ready=0; cmd_ready rises to 1 one clk after reset deasserts.
- Header word layout: opcode [31:28], index [15:0].
- Opcodes and payload word counts:
  - 0x1 SET_PERIOD, 1 word.
  - 0x2 SET_OUTER, 1 word.
  - 0x3 SET_STATE0, 1 word.
  - 0x4 WRITE_EDGE, 3 words: w0 = {ch_id, toggle} in bits [CH_LOG2:0], w1 = x, w2 = dx.
  - 0x5 COMMIT, 0 words.
  - 0x6 RUN, 0 words.
  - 0x7 STOP, 0 words.
- Payload words are truncated to the target field width (low bits kept).
- FSM states:
  - HDR: cmd_ready=1; decodes the header and enters PAYLOAD (loads the remaining-word count), COMMIT_WAIT, or stays in HDR.
  - PAYLOAD: cmd_ready=1; each accepted word writes its shadow field and decrements the count; returns to HDR after the last word.
  - COMMIT_WAIT: cmd_ready=0; commit_pending=1.
- Errors (all set err, sticky until reset):
  - Unknown opcode (0x0, 0x8-0xF): word dropped, stay in HDR.
  - WRITE_EDGE with index >= ED_MAX: all 3 payload words are consumed and discarded.
- Mirror counter: follows the core's rules while running && !pl_reset.
  - count increments; when count >= period: count := 0, outer_count increments.
  - When outer_count >= outer_period: outer_count := 0.
  - The compare is unsigned.
- frame_end = running && count >= period && outer_count >= outer_period.
- Commit application:
  - running=0: the cycle after COMMIT is accepted, the shadow bank copies into the active bank.
  - running=1: the copy happens on the cycle frame_end is true.
  - In both cases: pl_reset=1 for exactly 1 cycle, the mirror counter clears, the FSM returns to HDR, and commit_pending drops to 0 on the same edge.
- RUN: running := 1 and pl_reset := 0 on the next edge; no effect if already running.
- STOP: running := 0, pl_reset := 1, mirror counter cleared, next edge.
- The shadow bank is never visible on the outputs until a commit.
- A shadow write accepted on the same cycle as a commit lands in shadow only; in practice cmd_ready=0 in COMMIT_WAIT, so this cannot occur.
- Reset during COMMIT_WAIT aborts the commit; the active bank returns to zeros.
- period=0 is legal: count stays at 0 and outer_count advances every cycle.

Optional Feature:
- Macro: PULSE_SEQ_FRAME_IRQ_EN.
- When defined: adds output frame_irq (1 bit), a 1-cycle pulse on every frame_end, including one coinciding with a commit.
- frame_irq resets to 0 and never fires while stopped.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold reset 3 cycles, release -> all outputs 0, pl_reset=1, running=0; cmd_ready=1 at the 1st clk after release.
- Stopped load and commit: SET_PERIOD 4, SET_OUTER 2, SET_STATE0 0x05, WRITE_EDGE idx 1 {toggle=1, ch=3, x=2, dx=1}, COMMIT -> next cycle period=4, outer_period=2, state0=0x05, eds slot1 = {1,2,3,1}, one pl_reset pulse.
- Running commit alignment: RUN with period=4, outer_period=2, then SET_PERIOD 9 and COMMIT -> cmd_ready=0 and commit_pending=1 until frame_end (15 cycles after RUN); period becomes 9 on that edge; pl_reset pulses 1 cycle.
- Error handling: header 0xA0000000 -> err=1, no state change; WRITE_EDGE idx 20 with ED_MAX=16 -> 3 payload words accepted, eds unchanged, err stays 1.
- Backpressure/stall: deassert cmd_valid mid-payload of WRITE_EDGE for 5 cycles -> FSM holds in PAYLOAD; the edge is written correctly after the last word.
- Option on: period=1, outer_period=1, running -> frame_irq pulses every 4 cycles; STOP -> no further pulses.

Source files
------------

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: configuration sequencer for the N-channel pulse generator core.
//
// Accepts a valid/ready stream of 32-bit command words, stages period, outer_period,
// state0 and edge entries in a shadow bank, and swaps the shadow bank into the active
// bank at an outer-frame boundary (or immediately when stopped). Owns the core's
// synchronous reset and mirrors the core's frame counters to find frame boundaries.
//
// Optional feature macro: PULSE_SEQ_FRAME_IRQ_EN adds the frame_irq output.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   cmd_data       command/payload word
//   cmd_valid      cmd_data valid
//   cmd_ready      word accepted when cmd_valid && cmd_ready
//   period         active inner period
//   outer_period   active outer period
//   state0         active initial channel state
//   eds            active edge table, slot i at [i*ED_BITS +: ED_BITS], {dx, x, ch_id, toggle}
//   pl_reset       synchronous reset to the core
//   running        sequencer running
//   commit_pending commit requested, not yet applied
//   err            sticky protocol error
//   frame_irq      (optional) pulse on every frame end
//
// CH_LOG2 must be <= 5 so that state0 fits in one payload word.
module pulse_seq_ctrl #(
    parameter int unsigned COUNT_BITS = 32,
    parameter int unsigned CH_LOG2    = 3,
    parameter int unsigned ED_MAX     = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [31:0]                             cmd_data,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    output logic [COUNT_BITS-1:0]                   period,
    output logic [COUNT_BITS-1:0]                   outer_period,
    output logic [(1<<CH_LOG2)-1:0]                 state0,
    output logic [(1+CH_LOG2+2*COUNT_BITS)*ED_MAX-1:0] eds,
    output logic                                    pl_reset,
    output logic                                    running,
    output logic                                    commit_pending,
    output logic                                    err
`ifdef PULSE_SEQ_FRAME_IRQ_EN
    ,
    output logic                                    frame_irq
`endif
);

    localparam int unsigned CH_MAX   = 1 << CH_LOG2;
    localparam int unsigned ED_BITS  = 1 + CH_LOG2 + 2 * COUNT_BITS;
    localparam int unsigned X_LSB    = CH_LOG2 + 1;
    localparam int unsigned DX_LSB   = X_LSB + COUNT_BITS;
    localparam int unsigned IDX_BITS = (ED_MAX > 1) ? $clog2(ED_MAX) : 1;

    typedef enum logic [1:0] {StHdr, StPayload, StCommitWait} state_e;

    state_e                 state_q;
    logic [3:0]             op_q;
    logic [1:0]             wcnt_q;
    logic [IDX_BITS-1:0]    ed_idx_q;
    logic                   ed_drop_q;

    logic [COUNT_BITS-1:0]  sh_period_q, sh_outer_q, act_period_q, act_outer_q;
    logic [CH_MAX-1:0]      sh_state0_q, act_state0_q;
    logic [ED_BITS-1:0]     sh_eds_q  [ED_MAX];
    logic [ED_BITS-1:0]     act_eds_q [ED_MAX];

    logic [COUNT_BITS-1:0]  cnt_q, ocnt_q;
    logic                   running_q, pl_reset_q, cmd_ready_q, pending_q, err_q;

    logic       accept, frame_end, apply, idx_bad;
    logic [3:0] hdr_op;

    assign accept    = cmd_valid && cmd_ready_q;
    assign hdr_op    = cmd_data[31:28];
    assign idx_bad   = 32'(cmd_data[15:0]) >= ED_MAX;
    assign frame_end = running_q && (cnt_q >= act_period_q) && (ocnt_q >= act_outer_q);
    // Stopped: apply on the cycle after COMMIT; running: wait for the frame boundary.
    assign apply     = (state_q == StCommitWait) && (!running_q || frame_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StHdr;
            op_q         <= '0;
            wcnt_q       <= '0;
            ed_idx_q     <= '0;
            ed_drop_q    <= 1'b0;
            sh_period_q  <= '0;
            sh_outer_q   <= '0;
            sh_state0_q  <= '0;
            act_period_q <= '0;
            act_outer_q  <= '0;
            act_state0_q <= '0;
            for (int unsigned i = 0; i < ED_MAX; i++) begin
                sh_eds_q[i]  <= '0;
                act_eds_q[i] <= '0;
            end
            cnt_q        <= '0;
            ocnt_q       <= '0;
            running_q    <= 1'b0;
            pl_reset_q   <= 1'b1;
            cmd_ready_q  <= 1'b0;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // The commit pulse lasts one cycle, then pl_reset follows the run state.
            pl_reset_q <= !running_q;

            // Mirror of the core's frame counters.
            if (running_q && !pl_reset_q) begin
                if (cnt_q >= act_period_q) begin
                    cnt_q <= '0;
                    if (ocnt_q >= act_outer_q) ocnt_q <= '0;
                    else                       ocnt_q <= ocnt_q + COUNT_BITS'(1);
                end else begin
                    cnt_q <= cnt_q + COUNT_BITS'(1);
                end
            end

            case (state_q)
                StHdr: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        case (hdr_op)
                            4'h1, 4'h2, 4'h3: begin
                                op_q    <= hdr_op;
                                wcnt_q  <= '0;
                                state_q <= StPayload;
                            end
                            4'h4: begin
                                op_q      <= hdr_op;
                                wcnt_q    <= '0;
                                ed_idx_q  <= cmd_data[IDX_BITS-1:0];
                                ed_drop_q <= idx_bad;
                                if (idx_bad) err_q <= 1'b1;
                                state_q   <= StPayload;
                            end
                            4'h5: begin
                                state_q     <= StCommitWait;
                                cmd_ready_q <= 1'b0;
                                pending_q   <= 1'b1;
                            end
                            4'h6: begin
                                running_q  <= 1'b1;
                                pl_reset_q <= 1'b0;
                            end
                            4'h7: begin
                                running_q  <= 1'b0;
                                pl_reset_q <= 1'b1;
                                cnt_q      <= '0;
                                ocnt_q     <= '0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StPayload: begin
                    if (accept) begin
                        case (op_q)
                            4'h1: sh_period_q <= cmd_data[COUNT_BITS-1:0];
                            4'h2: sh_outer_q  <= cmd_data[COUNT_BITS-1:0];
                            4'h3: sh_state0_q <= cmd_data[CH_MAX-1:0];
                            default: begin
                                if (!ed_drop_q) begin
                                    case (wcnt_q)
                                        2'd0: sh_eds_q[ed_idx_q][CH_LOG2:0] <=
                                            cmd_data[CH_LOG2:0];
                                        2'd1: sh_eds_q[ed_idx_q][X_LSB +: COUNT_BITS] <=
                                            cmd_data[COUNT_BITS-1:0];
                                        default: sh_eds_q[ed_idx_q][DX_LSB +: COUNT_BITS] <=
                                            cmd_data[COUNT_BITS-1:0];
                                    endcase
                                end
                            end
                        endcase
                        if (op_q != 4'h4 || wcnt_q == 2'd2) state_q <= StHdr;
                        else                                wcnt_q  <= wcnt_q + 2'd1;
                    end
                end
                StCommitWait: begin
                    if (apply) begin
                        act_period_q <= sh_period_q;
                        act_outer_q  <= sh_outer_q;
                        act_state0_q <= sh_state0_q;
                        for (int unsigned i = 0; i < ED_MAX; i++) begin
                            act_eds_q[i] <= sh_eds_q[i];
                        end
                        pl_reset_q  <= 1'b1;
                        cnt_q       <= '0;
                        ocnt_q      <= '0;
                        state_q     <= StHdr;
                        cmd_ready_q <= 1'b1;
                        pending_q   <= 1'b0;
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    for (genvar g = 0; g < ED_MAX; g++) begin : g_eds
        assign eds[g*ED_BITS +: ED_BITS] = act_eds_q[g];
    end

    assign cmd_ready      = cmd_ready_q;
    assign period         = act_period_q;
    assign outer_period   = act_outer_q;
    assign state0         = act_state0_q;
    assign pl_reset       = pl_reset_q;
    assign running        = running_q;
    assign commit_pending = pending_q;
    assign err            = err_q;

`ifdef PULSE_SEQ_FRAME_IRQ_EN
    assign frame_irq = frame_end;
`endif

endmodule
